// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - iterative multiply/divide sequencer owning the HI/LO register pair
module hilo_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mf_req,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div, neg_q, neg_r, dz;

  logic        accept, start_md, last_step;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_rem;
  logic        div_ge;
  logic [63:0] mul_next, div_next, step_next, prod;
  logic [31:0] q_out, r_out;
  logic [63:0] commit_val;

  assign accept    = op_valid & op_ready & ~flush;
  assign start_md  = accept & ~op_code[2];
  assign last_step = (state == RUN) && (count == 5'd31);

  // Even op_codes (MULT/DIV) are the signed variants.
  assign a_neg = ~op_code[0] & op_a[31];
  assign b_neg = ~op_code[0] & op_b[31];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
  assign div_shift = acc[63:31];
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_rem   = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
  assign div_next  = {div_rem[31:0], acc[30:0], div_ge};

  assign step_next = is_div ? div_next : mul_next;

  // With a zero divisor every trial succeeds, so the remainder ends up as the signed dividend.
  assign prod  = neg_q ? -step_next : step_next;
  assign q_out = dz ? 32'hFFFF_FFFF : (neg_q ? -step_next[31:0] : step_next[31:0]);
  assign r_out = neg_r ? -step_next[63:32] : step_next[63:32];
  assign commit_val = is_div ? {r_out, q_out} : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_md) state_nxt = RUN;
      RUN:  if (flush || last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == IDLE);
    busy     = ~op_ready;
    stall    = busy & (op_valid | mf_req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (accept) begin
        case (op_code)
          3'b100: hi <= op_a;
          3'b101: lo <= op_a;
          3'b000, 3'b001, 3'b010, 3'b011: begin
            is_div <= op_code[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= op_code[1] & (op_b == 32'd0);
            opnd   <= op_code[1] ? b_mag : a_mag;
            acc    <= {32'd0, (op_code[1] ? a_mag : b_mag)};
            count  <= 5'd0;
          end
          default: ;
        endcase
      end else if (state == RUN && !flush) begin
        acc <= step_next;
        if (last_step) begin
          {hi, lo} <= commit_val;
          done     <= 1'b1;
          div_zero <= dz;
        end else begin
          count <= count + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - directed and random checks of hilo_sequencer against an arithmetic model
module tb_hilo_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        mf_req, flush;
  logic        op_ready, busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  hilo_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .mf_req(mf_req), .flush(flush),
    .op_ready(op_ready), .busy(busy), .stall(stall), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  task automatic model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    e_hi = m_hi; e_lo = m_lo; e_dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      3'd0: begin p = sa * sb; {e_hi, e_lo} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {e_hi, e_lo} = p; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          e_hi = a; e_lo = 32'hFFFF_FFFF; e_dz = 1'b1;
        end else if (code == 3'd2) begin
          q = sa / sb; r = sa % sb;
          e_lo = q[31:0]; e_hi = r[31:0];
        end else begin
          e_lo = a / b; e_hi = a % b;
        end
      end
      3'd4: e_hi = a;
      3'd5: e_lo = a;
      default: ;
    endcase
    m_hi = e_hi; m_lo = e_lo;
  endtask

  // Presents one op, waits for its result, returns in the done cycle (#1 after the commit edge).
  task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    logic e_dz;
    int cyc, rdy_low;
    model(code, a, b, e_hi, e_lo, e_dz);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    check("ready_before_op", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (code[2]) begin
      check("mt_hi", hi, e_hi);
      check("mt_lo", lo, e_lo);
      check("mt_no_done", done, 0);
      check("mt_ready", op_ready, 1);
    end else begin
      cyc = 0; rdy_low = 0;
      while (!done && cyc < 40) begin
        if (!op_ready) rdy_low++;
        @(posedge clk); #1;
        cyc++;
      end
      check("latency", cyc, 32);
      check("ready_low_cycles", rdy_low, 32);
      check("res_hi", hi, e_hi);
      check("res_lo", lo, e_lo);
      check("div_zero", div_zero, e_dz);
      check("ready_at_done", op_ready, 1);
    end
  endtask

  initial begin
    int cyc, n_stall, n_done;
    logic [2:0] rc;
    logic [31:0] ra, rb, e_hi, e_lo;
    logic e_dz;

    rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_a = 32'd0; op_b = 32'd0;
    mf_req = 1'b0; flush = 1'b0;
    #12;
    check("rst_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("plan_multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd3, 32'd100, 32'd7);
    check("plan_divu", {hi, lo}, 64'h0000_0002_0000_000E);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("plan_div_neg_a", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE);
    check("plan_div_neg_b", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    do_op(3'd2, 32'h1234, 32'd0);
    check("plan_div_zero", {hi, lo, div_zero, done}, {64'h0000_1234_FFFF_FFFF, 2'b11});
    do_op(3'd3, 32'h8000_0000, 32'd0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush mid-run, then MTLO; no done may appear.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd0; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_ready", op_ready, 1);
    check("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});
    do_op(3'd5, 32'h0000_ABCD, 32'd0);
    check("plan_mtlo", lo, 32'h0000_ABCD);
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
    check("flush_no_done", n_done, 0);

    // Flush in IDLE blocks MTHI.
    op_valid = 1'b1; op_code = 3'd4; op_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    check("flush_idle_mthi", hi, m_hi);

    for (int i = 0; i < 16; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op(rc, ra, rb);
    end

    // mf_req and a held DIVU during a MULT run; reset during the DIVU run.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd0; op_a = 32'h0001_0003; op_b = 32'hFFFF_0007;
    model(3'd0, op_a, op_b, e_hi, e_lo, e_dz);
    @(posedge clk); #1;
    op_code = 3'd3; op_a = 32'd1000; op_b = 32'd3; mf_req = 1'b1;
    cyc = 0; n_stall = 0;
    while (!done && cyc < 40) begin
      if (stall) n_stall++;
      @(posedge clk); #1;
      cyc++;
    end
    check("mf_stall_cycles", n_stall, 32);
    check("mf_result", {hi, lo}, {e_hi, e_lo});
    check("mf_no_stall_at_done", stall, 0);
    @(posedge clk); #1 op_valid = 1'b0;
    check("second_run_busy", op_ready, 0);
    n_stall = 0;
    repeat (20) begin
      if (stall) n_stall++;
      @(posedge clk); #1;
    end
    check("second_run_stall", n_stall, 20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", op_ready, 1);
    check("async_rst_outs", {hi, lo, busy, stall, done, div_zero}, 68'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    mf_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
    check("rst_no_done", n_done, 0);
    check("rst_final_hilo", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the execute stage and runs iterative 32-step shift-add multiply or restoring divide. It commits results to HI/LO and stalls the pipeline while the unit is occupied. Its hi/lo outputs are the "normal" source that feeds the execute-stage lo/hi forwarding mux.

## Interface
- No parameters. Data width is fixed at 32 and iteration count at 32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation presented this cycle.
- op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-op.
- op_a  in  32  rs operand (multiplicand / dividend / MT source).
- op_b  in  32  rt operand (multiplier / divisor).
- mf_req  in  1  an MFHI or MFLO is in decode this cycle.
- flush  in  1  abort any operation in flight; block new acceptance.
- op_ready  out  1  high in IDLE; acceptance is op_valid & op_ready & ~flush.
- busy  out  1  equal to ~op_ready.
- stall  out  1  busy & (op_valid | mf_req).
- done  out  1  one-cycle pulse when a MULT/DIV result is committed.
- div_zero  out  1  one-cycle pulse coincident with done for divide by zero.
- hi  out  32  registered HI value.
- lo  out  32  registered LO value.

## Operation
- States: IDLE and RUN.
- IDLE, accepted MTHI: hi <= op_a at the acceptance edge; state stays IDLE; no done pulse.
- IDLE, accepted MTLO: lo <= op_a at the acceptance edge; state stays IDLE; no done pulse.
- IDLE, accepted 110/111: no state change.
- IDLE, accepted MULT/MULTU/DIV/DIVU: latch operands, op type and result signs; count <= 0; go to RUN.
- Signed ops: operands are converted to magnitudes at acceptance.
- Signed multiply: the product is negated at commit if sign(a) != sign(b).
- Signed divide: the quotient is negated if signs differ; the remainder takes the sign of the dividend.
- Multiply: one shift-add step per RUN cycle on a 64-bit accumulator. Commit writes hi = product[63:32] and lo = product[31:0].
- Divide: one restoring step per RUN cycle. Commit writes lo = quotient and hi = remainder.
- Divide by zero (op_b == 0, detected at acceptance): runs the full 32 cycles. Commit writes hi = op_a (unmodified) and lo = 32'hFFFFFFFF, for both signed and unsigned. div_zero pulses.
- RUN, count == 31: commit hi/lo, done <= 1, state <= IDLE.
- RUN, count < 31: count <= count + 1.
- flush in RUN: state <= IDLE at the next edge. hi/lo keep their pre-operation values, and done/div_zero are not pulsed.
- flush in IDLE: the operation is not accepted, including MTHI/MTLO.
- op_valid while busy: not accepted; stall is high; the requester holds op_valid and operands until op_ready.
- mf_req while busy: stall is high until the commit edge. In the first IDLE cycle, hi/lo already show the new result, so no forwarding is needed from this block.
- Reset (async, any state): state IDLE, count 0, hi 0, lo 0, done 0, div_zero 0, op_ready 1, busy 0, stall 0. An operation in flight at reset is discarded.

## Timing
- MTHI/MTLO: hi/lo updated at the acceptance edge and visible the following cycle (latency 1).
- MULT/DIV accepted at edge E0:
  - op_ready goes low in the cycle after E0.
  - RUN iterations happen on edges E1..E32.
  - Commit happens at E32.
  - done is high in the cycle following E32, as is op_ready.
- Throughput: a new op can be accepted in the same cycle done is high, giving back-to-back ops 33 cycles apart.
- stall and op_ready are combinational from registered state plus op_valid/mf_req. done and div_zero are registered.

## Test plan
- Reset then MULT a=32'hFFFFFFFD (-3), b=5 -> done exactly 32 cycles after acceptance; hi=FFFFFFFF, lo=FFFFFFF1; op_ready low for 32 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Also DIVU 100/7 -> lo=0000000E, hi=00000002.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. Also DIV 7/-2 -> lo=FFFFFFFD, hi=00000001.
- DIV a=1234, b=0 -> done and div_zero pulse together at 32 cycles; hi=00001234, lo=FFFFFFFF.
- MULT accepted, then flush at cycle 10, then MTLO 0xABCD -> no done pulse; hi unchanged; lo=ABCD one cycle after MTLO acceptance.
- mf_req plus a held second op_valid during RUN, with rst_n pulsed low at cycle 20 of a second run -> stall high during RUN until reset. After reset all outputs are zero and op_ready=1, with no later done pulse.
